rx_frame_unpacker: RTL and testbench

- Read-domain stage directly downstream of the low-to-high-speed transfer FIFO.
- Runs on the fast read clock. Pops 9-bit words (8 data bits plus 1 parity bit) from the FIFO read port and checks parity on each word.
- Forwards bytes on a valid/ready stream, grouped into fixed-length frames with a last-beat marker and a running mod-256 checksum.
- Reports parity errors through a sticky flag and a saturating counter.

---
 rtl/rx_frame_unpacker_pkg.sv | 24 ++
 rtl/rx_frame_unpacker_if.sv | 35 +++
 rtl/rx_frame_unpacker_skid_buf2.sv | 67 ++++++
 rtl/rx_frame_unpacker.sv | 145 ++++++++++++++
 tb/tb_rx_frame_unpacker.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rx_frame_unpacker_pkg.sv
// rx_frame_unpacker_pkg
// Definitions shared by the read-side unpacker and the write-side parity
// generator of the slow-to-fast transfer path.
//   DW_DEF            default data width (parity bit excluded)
//   PAR_EVEN/PAR_ODD  parity-mode selectors
//   frame_state_e     frame sequencer states
//   parity_bit()      parity bit to append to a data word for a given mode
package rx_frame_unpacker_pkg;

    localparam int DW_DEF   = 8;
    localparam bit PAR_EVEN = 1'b0;
    localparam bit PAR_ODD  = 1'b1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } frame_state_e;

    // The appended bit makes the 9-bit word's total count of ones match the mode.
    function automatic logic parity_bit(input logic [DW_DEF-1:0] data, input bit odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/rx_frame_unpacker_if.sv
// rx_frame_unpacker_if
// Bundles the FIFO read port, the output byte stream and the parity-error
// status of the unpacker.
//   master: the unpacker side (pops the FIFO, drives the stream and status)
//   slave : the environment side (FIFO read port, stream sink, status reader)
interface rx_frame_unpacker_if #(
    parameter int DW    = 8,
    parameter int CNT_W = 8
);
    logic [DW:0]      fifo_dout;
    logic             fifo_empty;
    logic             fifo_rd_en;
    logic [DW-1:0]    m_data;
    logic             m_valid;
    logic             m_ready;
    logic             m_last;
    logic             m_err;
    logic [DW-1:0]    m_csum;
    logic             m_frame_bad;
    logic             pe;
    logic             pe_clr;
    logic [CNT_W-1:0] err_count;

    modport master (
        input  fifo_dout, fifo_empty, m_ready, pe_clr,
        output fifo_rd_en, m_data, m_valid, m_last, m_err, m_csum,
               m_frame_bad, pe, err_count
    );

    modport slave (
        output fifo_dout, fifo_empty, m_ready, pe_clr,
        input  fifo_rd_en, m_data, m_valid, m_last, m_err, m_csum,
               m_frame_bad, pe, err_count
    );
endinterface

// File: rtl/rx_frame_unpacker_skid_buf2.sv
// rx_frame_unpacker_skid_buf2
// Two-entry in-order buffer. Entry 0 is always the head.
//   clk_i, rst_i   clock, async active-high reset
//   wr_en_i        write wr_data_i this cycle
//   rd_en_i        drop the head this cycle (ignored when empty)
//   head_o         current head entry (zero after reset)
//   occ_o          number of entries held (0..2)
module rx_frame_unpacker_skid_buf2 #(
    parameter int W = 9
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         wr_en_i,
    input  logic [W-1:0] wr_data_i,
    input  logic         rd_en_i,
    output logic [W-1:0] head_o,
    output logic [1:0]   occ_o
);
    logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
    logic [1:0]   occ_q, occ_d;
    logic         rd, wr;

    assign rd = rd_en_i && (occ_q != 2'd0);
    // A write into a full buffer is only accepted when the head leaves on the same cycle.
    assign wr = wr_en_i && ((occ_q != 2'd2) || rd);

    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        occ_d = occ_q;
        case ({wr, rd})
            2'b01: begin
                e0_d  = e1_q;
                occ_d = occ_q - 2'd1;
            end
            2'b10: begin
                if (occ_q == 2'd0) e0_d = wr_data_i;
                else               e1_d = wr_data_i;
                occ_d = occ_q + 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    e0_d = wr_data_i;
                end else begin
                    e0_d = e1_q;
                    e1_d = wr_data_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            e0_q  <= '0;
            e1_q  <= '0;
            occ_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            occ_q <= occ_d;
        end
    end

    assign head_o = e0_q;
    assign occ_o  = occ_q;
endmodule

// File: rtl/rx_frame_unpacker.sv
// rx_frame_unpacker
// Pops parity-protected words from the transfer FIFO, checks parity, and
// forwards the bytes as fixed-length frames with a running checksum.
//   rclk   read-domain clock
//   rst    async active-high reset
//   bus    FIFO read port, output stream (data/valid/ready/last/err/csum/
//          frame_bad) and parity status (pe, pe_clr, err_count)
//
// Frame sequencer:
//   state     | meaning
//   ST_IDLE   | no beat of the current frame transferred yet; counter/sum/bad are zero
//   ST_ACTIVE | frame in progress; counter holds the number of beats already transferred
module rx_frame_unpacker
    import rx_frame_unpacker_pkg::*;
#(
    parameter int DW         = DW_DEF,
    parameter int FRAME_LEN  = 16,
    parameter bit PARITY_ODD = PAR_EVEN,
    parameter int CNT_W      = 8
) (
    input  logic                rclk,
    input  logic                rst,
    rx_frame_unpacker_if.master bus
);
    localparam int             CW       = (FRAME_LEN <= 2) ? 1 : $clog2(FRAME_LEN);
    localparam logic [CW-1:0]  LAST_IDX = CW'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]       occ;
    logic [DW:0]      head;
    logic             in_flight_q;
    logic             cap_err;
    logic             xfer;

    frame_state_e     state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DW-1:0]    sum_q, sum_d;
    logic             bad_q, bad_d;

    logic             pe_q, pe_d;
    logic [CNT_W-1:0] errc_q, errc_d;

    // Entries held plus the word already popped must leave room for one more.
    // Gated by rst so no pop is requested while the block is held in reset.
    assign bus.fifo_rd_en = !rst && !bus.fifo_empty &&
                            ((occ + {1'b0, in_flight_q}) <= 2'd1);

    always_ff @(posedge rclk or posedge rst) begin
        if (rst) in_flight_q <= 1'b0;
        else     in_flight_q <= bus.fifo_rd_en;
    end

    assign cap_err = (^bus.fifo_dout) != PARITY_ODD;

    rx_frame_unpacker_skid_buf2 #(.W(DW + 1)) u_buf (
        .clk_i     (rclk),
        .rst_i     (rst),
        .wr_en_i   (in_flight_q),
        .wr_data_i ({bus.fifo_dout[DW-1:0], cap_err}),
        .rd_en_i   (xfer),
        .head_o    (head),
        .occ_o     (occ)
    );

    assign bus.m_valid     = (occ != 2'd0);
    assign xfer            = bus.m_valid && bus.m_ready;
    assign bus.m_data      = head[DW:1];
    assign bus.m_err       = head[0];
    assign bus.m_last      = (cnt_q == LAST_IDX);
    assign bus.m_csum      = sum_q + bus.m_data;
    assign bus.m_frame_bad = bad_q | bus.m_err;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        bad_d   = bad_q;
        if (xfer) begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ACTIVE;
                    cnt_d   = CW'(1);
                    sum_d   = bus.m_data;
                    bad_d   = bus.m_err;
                end
                ST_ACTIVE: begin
                    if (cnt_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        sum_d   = '0;
                        bad_d   = 1'b0;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        sum_d   = sum_q + bus.m_data;
                        bad_d   = bad_q | bus.m_err;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sum_q   <= '0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            bad_q   <= bad_d;
        end
    end

    // Errors are counted when the word enters the buffer, so a stalled
    // stream still reports them. A capture error overrides a same-cycle clear.
    always_comb begin
        pe_d   = pe_q;
        errc_d = errc_q;
        if (bus.pe_clr) begin
            pe_d   = 1'b0;
            errc_d = '0;
        end
        if (in_flight_q && cap_err) begin
            pe_d = 1'b1;
            if (bus.pe_clr)            errc_d = CNT_W'(1);
            else if (errc_q != CNT_MAX) errc_d = errc_q + 1'b1;
        end
    end

    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            pe_q   <= 1'b0;
            errc_q <= '0;
        end else begin
            pe_q   <= pe_d;
            errc_q <= errc_d;
        end
    end

    assign bus.pe        = pe_q;
    assign bus.err_count = errc_q;
endmodule

// File: tb/tb_rx_frame_unpacker.sv
module tb_rx_frame_unpacker;
    import rx_frame_unpacker_pkg::*;

    logic rclk = 1'b0;
    logic rst  = 1'b1;
    always #5 rclk = ~rclk;

    rx_frame_unpacker_if #(.DW(8), .CNT_W(8)) bus ();

    rx_frame_unpacker #(
        .DW(8), .FRAME_LEN(16), .PARITY_ODD(PAR_EVEN), .CNT_W(8)
    ) dut (
        .rclk (rclk),
        .rst  (rst),
        .bus  (bus)
    );

    typedef struct {
        logic [7:0] d;
        logic       e;
        logic       l;
        logic [7:0] cs;
        logic       fb;
    } beat_t;

    beat_t      obs[$];
    logic [8:0] fq[$];

    int   n_chk = 0, n_fail = 0;
    int   cyc = 0;
    bit   rd_pend = 1'b0;
    int   pop_cnt = 0, emp_viol = 0, hold_viol = 0, under_viol = 0;
    bit   ready_set = 1'b0, rnd_en = 1'b0, tog_en = 1'b0;
    bit   clr_req = 1'b0, clr_arm = 1'b0;
    int   lat_rd = -1, lat_v = -1;
    bit   hold_prev = 1'b0;
    logic [18:0] prev_vec = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] mkw(input logic [7:0] d, input bit bad);
        return {parity_bit(d, PAR_EVEN) ^ bad, d};
    endfunction

    task automatic push(input logic [7:0] d, input bit bad);
        fq.push_back(mkw(d, bad));
    endtask

    task automatic wait_obs(input int n, input int budget);
        int k = 0;
        while (obs.size() < n && k < budget) begin
            @(negedge rclk);
            k++;
        end
        if (obs.size() < n) chk("timeout", obs.size(), n);
    endtask

    task automatic pulse_clr();
        clr_req = 1'b1;
        @(posedge rclk);
        #2 clr_req = 1'b0;
        @(posedge rclk);
        @(negedge rclk);
    endtask

    initial begin
        bus.fifo_dout  = '0;
        bus.fifo_empty = 1'b1;
        bus.m_ready    = 1'b0;
        bus.pe_clr     = 1'b0;
        fork
            // FIFO read port, stream sink and pe_clr driver: updates 1 ns after each edge
            forever begin
                @(posedge rclk);
                #1;
                bus.pe_clr = clr_req;
                if (rd_pend && !rst) begin
                    if (fq.size() == 0) under_viol++;
                    else bus.fifo_dout = fq.pop_front();
                    if (clr_arm) begin
                        bus.pe_clr = 1'b1;
                        clr_arm    = 1'b0;
                    end
                end
                bus.fifo_empty = (fq.size() == 0) || (tog_en && cyc[0]);
                bus.m_ready    = rnd_en ? 1'($urandom_range(0, 1)) : ready_set;
            end
            // Monitor on the falling edge
            forever begin
                @(negedge rclk);
                cyc++;
                if (!rst) begin
                    if (bus.fifo_rd_en && bus.fifo_empty) emp_viol++;
                    if (bus.fifo_rd_en) pop_cnt++;
                    if (lat_rd < 0 && bus.fifo_rd_en) lat_rd = cyc;
                    if (lat_v < 0 && bus.m_valid) lat_v = cyc;
                    if (hold_prev && ({bus.m_data, bus.m_err, bus.m_last, bus.m_csum,
                                       bus.m_frame_bad} != prev_vec)) hold_viol++;
                    hold_prev = bus.m_valid && !bus.m_ready;
                    prev_vec  = {bus.m_data, bus.m_err, bus.m_last, bus.m_csum, bus.m_frame_bad};
                    if (bus.m_valid && bus.m_ready) begin
                        beat_t b;
                        b.d  = bus.m_data;
                        b.e  = bus.m_err;
                        b.l  = bus.m_last;
                        b.cs = bus.m_csum;
                        b.fb = bus.m_frame_bad;
                        obs.push_back(b);
                    end
                end else begin
                    hold_prev = 1'b0;
                end
                rd_pend = bus.fifo_rd_en && !rst;
            end
            // Directed stimulus
            begin
                int mm;
                repeat (3) @(negedge rclk);
                chk("rst_valid", bus.m_valid, 0);
                chk("rst_rd_en", bus.fifo_rd_en, 0);
                chk("rst_data", bus.m_data, 0);
                chk("rst_csum", bus.m_csum, 0);
                chk("rst_last", bus.m_last, 0);
                chk("rst_pe", bus.pe, 0);
                chk("rst_errcnt", bus.err_count, 0);
                #2 rst = 1'b0;

                // Continuous stream 0x01..0x20
                ready_set = 1'b1;
                lat_rd = -1; lat_v = -1;
                obs.delete();
                for (int i = 1; i <= 32; i++) push(8'(i), 1'b0);
                wait_obs(32, 400);
                repeat (4) @(negedge rclk);
                chk("t1_latency", lat_v - lat_rd, 2);
                chk("t1_count", obs.size(), 32);
                mm = 0;
                for (int i = 0; i < obs.size(); i++) begin
                    if (obs[i].d !== 8'(i + 1)) mm++;
                    if (obs[i].l !== 1'(i % 16 == 15)) mm++;
                    if (obs[i].e !== 1'b0) mm++;
                end
                chk("t1_seq", mm, 0);
                chk("t1_last16", obs[15].l, 1);
                chk("t1_csum16", obs[15].cs, 'h88);
                chk("t1_csum32", obs[31].cs, 'h88);
                chk("t1_fbad16", obs[15].fb, 0);
                chk("t1_pe", bus.pe, 0);

                // One bad-parity word at beat 3
                obs.delete();
                for (int i = 0; i < 32; i++) begin
                    if (i == 2) push(8'h05, 1'b1);
                    else        push(8'(8'h60 + i), 1'b0);
                end
                wait_obs(32, 400);
                repeat (4) @(negedge rclk);
                mm = 0;
                for (int i = 0; i < obs.size(); i++)
                    if (obs[i].e !== 1'(i == 2)) mm++;
                chk("t2_err_beats", mm, 0);
                chk("t2_data3", obs[2].d, 'h05);
                chk("t2_err3", obs[2].e, 1);
                chk("t2_fbad1", obs[15].fb, 1);
                chk("t2_fbad2", obs[31].fb, 0);
                chk("t2_last2", obs[31].l, 1);
                chk("t2_pe", bus.pe, 1);
                chk("t2_errcnt", bus.err_count, 1);
                pulse_clr();
                chk("t2_clr_pe", bus.pe, 0);
                chk("t2_clr_cnt", bus.err_count, 0);

                // Backpressure
                obs.delete();
                ready_set = 1'b0;
                @(posedge rclk);
                #2;
                pop_cnt = 0;
                hold_viol = 0;
                for (int i = 0; i < 10; i++) push(8'(8'hA0 + i), 1'b0);
                repeat (20) @(negedge rclk);
                chk("t3_pops", pop_cnt, 2);
                chk("t3_rd_en", bus.fifo_rd_en, 0);
                chk("t3_valid", bus.m_valid, 1);
                chk("t3_head", bus.m_data, 'hA0);
                chk("t3_none_out", obs.size(), 0);
                ready_set = 1'b1;
                wait_obs(10, 200);
                repeat (10) @(negedge rclk);
                chk("t3_count", obs.size(), 10);
                mm = 0;
                for (int i = 0; i < obs.size(); i++)
                    if (obs[i].d !== 8'(8'hA0 + i)) mm++;
                chk("t3_order", mm, 0);
                chk("t3_stable", hold_viol, 0);

                // Toggling empty with random ready
                obs.delete();
                emp_viol = 0;
                hold_viol = 0;
                tog_en = 1'b1;
                rnd_en = 1'b1;
                for (int i = 0; i < 40; i++) push(8'(i * 37 + 11), 1'b0);
                wait_obs(40, 3000);
                tog_en = 1'b0;
                rnd_en = 1'b0;
                ready_set = 1'b1;
                repeat (6) @(negedge rclk);
                chk("t4_count", obs.size(), 40);
                mm = 0;
                for (int i = 0; i < obs.size(); i++)
                    if (obs[i].d !== 8'(i * 37 + 11)) mm++;
                chk("t4_order", mm, 0);
                chk("t4_no_empty_pop", emp_viol, 0);
                chk("t4_stable", hold_viol, 0);
                chk("t4_underflow", under_viol, 0);

                // Saturating error counter
                obs.delete();
                for (int i = 0; i < 300; i++) push(8'(i), 1'b1);
                wait_obs(300, 3000);
                repeat (4) @(negedge rclk);
                chk("t5_sat", bus.err_count, 255);
                chk("t5_pe", bus.pe, 1);
                mm = 0;
                for (int i = 0; i < obs.size(); i++)
                    if (obs[i].e !== 1'b1) mm++;
                chk("t5_err_flags", mm, 0);
                obs.delete();
                clr_arm = 1'b1;
                push(8'h3C, 1'b1);
                wait_obs(1, 50);
                repeat (2) @(negedge rclk);
                chk("t5_clr_cnt", bus.err_count, 1);
                chk("t5_clr_pe", bus.pe, 1);

                // Reset mid-frame
                obs.delete();
                for (int i = 0; i < 20; i++) push(8'(8'h10 + i), 1'b0);
                wait_obs(7, 200);
                #2 rst = 1'b1;
                #1;
                chk("t6_valid", bus.m_valid, 0);
                chk("t6_rd_en", bus.fifo_rd_en, 0);
                chk("t6_data", bus.m_data, 0);
                chk("t6_last", bus.m_last, 0);
                chk("t6_err", bus.m_err, 0);
                chk("t6_csum", bus.m_csum, 0);
                chk("t6_fbad", bus.m_frame_bad, 0);
                chk("t6_pe", bus.pe, 0);
                chk("t6_errcnt", bus.err_count, 0);
                fq.delete();
                repeat (3) @(negedge rclk);
                obs.delete();
                #2 rst = 1'b0;
                for (int i = 0; i < 16; i++) push(8'(8'h42 + i), 1'b0);
                wait_obs(16, 300);
                repeat (5) @(negedge rclk);
                chk("t6_count", obs.size(), 16);
                mm = 0;
                for (int i = 0; i < obs.size(); i++) begin
                    if (obs[i].d !== 8'(8'h42 + i)) mm++;
                    if (obs[i].l !== 1'(i == 15)) mm++;
                end
                chk("t6_seq", mm, 0);
                chk("t6_last16", obs[15].l, 1);
                chk("t6_csum16", obs[15].cs, 'h98);

                $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
                $finish;
            end
        join
    end
endmodule
